// File: rtl/snn_uart_pkg.sv
// Shared types and constants for the SNN result UART transmitter.
// Optional macro SNN_UART_CKSUM_EN appends an XOR checksum byte to every frame.
package snn_uart_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         RES_W     = 32;

`ifdef SNN_UART_CKSUM_EN
  localparam int FRAME_BYTES = 6;
`else
  localparam int FRAME_BYTES = 5;
`endif

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  typedef struct packed {
    logic signed [15:0] p1;
    logic signed [15:0] p2;
  } result_t;

  // Byte idx of the frame built around result r: sync, p1 hi/lo, p2 hi/lo [, xor].
  function automatic logic [7:0] frame_byte(input result_t r, input logic [2:0] idx);
    logic [7:0] b;
    b = SYNC_BYTE;
    case (idx)
      3'd1:    b = r.p1[15:8];
      3'd2:    b = r.p1[7:0];
      3'd3:    b = r.p2[15:8];
      3'd4:    b = r.p2[7:0];
`ifdef SNN_UART_CKSUM_EN
      3'd5:    b = r.p1[15:8] ^ r.p1[7:0] ^ r.p2[15:8] ^ r.p2[7:0];
`endif
      default: b = SYNC_BYTE;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/snn_uart_fifo.sv
// Synchronous result FIFO; a push while full is ignored unless a pop frees the slot.
module snn_uart_fifo
  import snn_uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = RES_W
) (
  input  logic             wb_clk,
  input  logic             wb_rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Occupancy flags and qualified push/pop strobes.
  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    rd_data = mem[rd_ptr[AW-1:0]];
  end

  // Pointer update; extra MSB distinguishes full from empty.
  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge wb_clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/snn_result_uart_tx.sv
// Decimates SNN result strobes, buffers results and sends each as an 8N1 byte frame.
// Optional macro SNN_UART_CKSUM_EN adds a sixth XOR checksum byte per frame.
module snn_result_uart_tx
  import snn_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 386,
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_W        = 16
) (
  input  logic               wb_clk,
  input  logic               wb_rst_n,
  input  logic               i_valid,
  input  logic signed [15:0] i_p1,
  input  logic signed [15:0] i_p2,
  input  logic [31:0]        i_decim,
  output logic               o_q,
  output logic               o_busy,
  output logic               o_drop,
  output logic [CNT_W-1:0]   o_frame_cnt
);

  localparam int             TW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0]  TMAX      = TW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     LAST_BYTE = 3'(FRAME_BYTES - 1);

  logic [31:0]   sc_q;
  logic [31:0]   stride_lim;
  logic          accept;

  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [RES_W-1:0] fifo_rd;

  tx_state_t     state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_q, bit_d;
  logic [2:0]    byte_q, byte_d;
  logic          bit_end;
  logic          frame_done;
  logic          line_d;
  logic [7:0]    cur_byte;
  result_t       res_q;

  // Stride decision: zero stride behaves as one, accept when counter is at zero.
  always_comb begin
    stride_lim = (i_decim == 32'd0) ? 32'd0 : i_decim - 32'd1;
    accept     = i_valid && (sc_q == 32'd0);
  end

  // Stride counter advances on every strobe and wraps at the current limit.
  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n)    sc_q <= 32'd0;
    else if (i_valid) sc_q <= (sc_q < stride_lim) ? sc_q + 32'd1 : 32'd0;
  end

  snn_uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (RES_W)
  ) u_fifo (
    .wb_clk   (wb_clk),
    .wb_rst_n (wb_rst_n),
    .push     (accept),
    .pop      (fifo_pop),
    .wr_data  ({i_p1, i_p2}),
    .rd_data  (fifo_rd),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Drop pulse when an accepted result finds the FIFO full with no pop this cycle.
  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) o_drop <= 1'b0;
    else           o_drop <= accept && fifo_full && !fifo_pop;
  end

  // Bit FSM next state, bit timer, byte sequencer and line level.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    fifo_pop   = 1'b0;
    frame_done = 1'b0;
    bit_end    = (timer_q == TMAX);
    cur_byte   = frame_byte(res_q, byte_q);
    line_d     = 1'b1;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        bit_d   = 3'd0;
        byte_d  = 3'd0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = START;
        end
      end
      START: begin
        line_d = 1'b0;
        if (bit_end) begin
          timer_d = '0;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      DATA: begin
        line_d = cur_byte[bit_q];
        if (bit_end) begin
          timer_d = '0;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          timer_d = '0;
          if (byte_q == LAST_BYTE) begin
            frame_done = 1'b1;
            state_d    = IDLE;
          end else begin
            byte_d  = byte_q + 3'd1;
            state_d = START;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers: FSM state, counters, registered line and frame count.
  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      bit_q       <= 3'd0;
      byte_q      <= 3'd0;
      o_q         <= 1'b1;
      o_frame_cnt <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      o_q     <= line_d;
      if (frame_done) o_frame_cnt <= o_frame_cnt + CNT_W'(1);
    end
  end

  // Result being framed, captured on pop.
  always_ff @(posedge wb_clk) begin
    if (fifo_pop) res_q <= result_t'(fifo_rd);
  end

  assign o_busy = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_snn_result_uart_tx.sv
// Self-checking bench for snn_result_uart_tx with a UART receiver and a frame-level model.
module tb_snn_result_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef SNN_UART_CKSUM_EN
  localparam int FB = 6;
`else
  localparam int FB = 5;
`endif

  logic        wb_clk;
  logic        wb_rst_n;
  logic        i_valid;
  logic [15:0] i_p1;
  logic [15:0] i_p2;
  logic [31:0] i_decim;
  logic        o_q;
  logic        o_busy;
  logic        o_drop;
  logic [15:0] o_frame_cnt;

  int checks = 0;
  int errors = 0;

  // receiver state
  logic [7:0] rx_bytes[$];
  longint     start_times[$];
  bit         rx_active = 0;
  int         rx_cnt = 0;
  logic [7:0] rx_sh;
  logic       q_prev = 1'b1;
  int         drop_cnt = 0;

  // model state
  logic [15:0] sq_p1[$];
  logic [15:0] sq_p2[$];
  logic [7:0]  exp_bytes[$];
  int          exp_frames;
  int          exp_drops;

  snn_result_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .CNT_W        (16)
  ) dut (
    .wb_clk      (wb_clk),
    .wb_rst_n    (wb_rst_n),
    .i_valid     (i_valid),
    .i_p1        (i_p1),
    .i_p2        (i_p2),
    .i_decim     (i_decim),
    .o_q         (o_q),
    .o_busy      (o_busy),
    .o_drop      (o_drop),
    .o_frame_cnt (o_frame_cnt)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  // UART receiver: detect start falling edge, sample each bit at its middle.
  always @(negedge wb_clk) begin
    if (!wb_rst_n) begin
      rx_active = 0;
      q_prev    = 1'b1;
    end else begin
      if (o_drop) drop_cnt++;
      if (!rx_active) begin
        if (q_prev && !o_q) begin
          rx_active = 1;
          rx_cnt    = 0;
          start_times.push_back($time);
        end
      end else begin
        rx_cnt++;
        if (rx_cnt % CPB == CPB / 2) begin
          if (rx_cnt / CPB >= 1 && rx_cnt / CPB <= 8) rx_sh[rx_cnt / CPB - 1] = o_q;
          if (rx_cnt / CPB == 9) begin
            checks++;
            if (o_q !== 1'b1) begin
              errors++;
              $display("FAIL stop_bit got %b want 1 at %0t", o_q, $time);
            end
            rx_bytes.push_back(rx_sh);
            rx_active = 0;
          end
        end
      end
      q_prev = o_q;
    end
  end

  task automatic do_reset();
    @(negedge wb_clk);
    wb_rst_n = 1'b0;
    i_valid  = 1'b0;
    repeat (2) @(negedge wb_clk);
    wb_rst_n = 1'b1;
    @(negedge wb_clk);
    rx_bytes.delete();
    start_times.delete();
    sq_p1.delete();
    sq_p2.delete();
    drop_cnt = 0;
  endtask

  // Drive one strobe for one cycle (call right after a falling edge).
  task automatic strobe(input logic [15:0] p1, input logic [15:0] p2);
    i_valid = 1'b1;
    i_p1    = p1;
    i_p2    = p2;
    sq_p1.push_back(p1);
    sq_p2.push_back(p2);
    @(negedge wb_clk);
    i_valid = 1'b0;
  endtask

  // Reference: every stride-th strobe is kept; within one burst the transmitter
  // takes one result and the FIFO holds DEPTH more, the rest are dropped.
  task automatic build_expected(input int decim);
    int stride;
    int acc;
    logic [7:0] b[6];
    stride = (decim == 0) ? 1 : decim;
    acc = 0;
    exp_bytes.delete();
    exp_frames = 0;
    exp_drops  = 0;
    for (int i = 0; i < sq_p1.size(); i++) begin
      if (i % stride == 0) begin
        if (acc < DEPTH + 1) begin
          b[0] = 8'hA5;
          b[1] = sq_p1[i][15:8];
          b[2] = sq_p1[i][7:0];
          b[3] = sq_p2[i][15:8];
          b[4] = sq_p2[i][7:0];
          b[5] = b[1] ^ b[2] ^ b[3] ^ b[4];
          for (int k = 0; k < FB; k++) exp_bytes.push_back(b[k]);
          exp_frames++;
        end else begin
          exp_drops++;
        end
        acc++;
      end
    end
  endtask

  task automatic wait_idle(input string name, input int limit);
    bit ok;
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge wb_clk);
      if (!o_busy && !rx_active) begin
        ok = 1;
        break;
      end
    end
    repeat (2 * CPB) @(negedge wb_clk);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout busy=%b still set after %0d cycles", name, o_busy, limit);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (o_q !== 1'b1)       begin errors++; $display("FAIL reset_q got %b want 1", o_q); end
    checks++; if (o_busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", o_busy); end
    checks++; if (o_drop !== 1'b0)    begin errors++; $display("FAIL reset_drop got %b want 0", o_drop); end
    checks++; if (o_frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", o_frame_cnt); end
  endtask

  task automatic test_single();
    longint t0;
    do_reset();
    i_decim = 32'd1;
    t0 = $time;
    strobe(16'h0123, 16'hFFFE);
    build_expected(1);
    wait_idle("single", 2000);
    checks++;
    if (start_times.size() == 0 || start_times[0] - t0 != 30) begin
      errors++;
      $display("FAIL single_latency got %0d want 30 time units", start_times.size() ? start_times[0] - t0 : -1);
    end
    checks++; if (rx_bytes.size() != exp_bytes.size()) begin errors++; $display("FAIL single_len got %0d want %0d", rx_bytes.size(), exp_bytes.size()); end
    for (int i = 0; i < exp_bytes.size() && i < rx_bytes.size(); i++) begin
      checks++; if (rx_bytes[i] !== exp_bytes[i]) begin errors++; $display("FAIL single_byte%0d got %h want %h", i, rx_bytes[i], exp_bytes[i]); end
    end
    checks++; if (o_frame_cnt !== 16'd1) begin errors++; $display("FAIL single_cnt got %0d want 1", o_frame_cnt); end
    checks++; if (o_busy !== 1'b0)       begin errors++; $display("FAIL single_busy got %b want 0", o_busy); end
  endtask

  // Covers both the stride scenario and the overflow scenario.
  task automatic test_burst(input string name, input int decim, input int n);
    do_reset();
    i_decim = decim;
    for (int i = 0; i < n; i++) strobe(16'(i), 16'(i * 3 + 7));
    build_expected(decim);
    wait_idle(name, 6000);
    checks++; if (rx_bytes.size() != exp_bytes.size()) begin errors++; $display("FAIL %s_len got %0d want %0d", name, rx_bytes.size(), exp_bytes.size()); end
    for (int i = 0; i < exp_bytes.size() && i < rx_bytes.size(); i++) begin
      checks++; if (rx_bytes[i] !== exp_bytes[i]) begin errors++; $display("FAIL %s_byte%0d got %h want %h", name, i, rx_bytes[i], exp_bytes[i]); end
    end
    checks++; if (o_frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL %s_cnt got %0d want %0d", name, o_frame_cnt, exp_frames); end
    checks++; if (drop_cnt != exp_drops) begin errors++; $display("FAIL %s_drops got %0d want %0d", name, drop_cnt, exp_drops); end
  endtask

  task automatic test_timing();
    longint want;
    do_reset();
    i_decim = 32'd1;
    strobe(16'h5A5A, 16'h0F0F);
    strobe(16'hC3C3, 16'h8001);
    wait_idle("timing", 3000);
    checks++; if (start_times.size() != 2 * FB) begin errors++; $display("FAIL timing_starts got %0d want %0d", start_times.size(), 2 * FB); end
    for (int i = 1; i < start_times.size(); i++) begin
      want = (i == FB) ? 410 : 400;
      checks++;
      if (start_times[i] - start_times[i-1] != want) begin
        errors++;
        $display("FAIL timing_gap%0d got %0d want %0d", i, start_times[i] - start_times[i-1], want);
      end
    end
    checks++; if (o_frame_cnt !== 16'd2) begin errors++; $display("FAIL timing_cnt got %0d want 2", o_frame_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    do_reset();
    i_decim = 32'd1;
    strobe(16'h1111, 16'h2222);
    strobe(16'h3333, 16'h4444);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (start_times.size() >= 2) begin ok = 1; break; end
      @(negedge wb_clk);
    end
    checks++; if (!ok) begin errors++; $display("FAIL midrst_timeout starts got %0d want 2", start_times.size()); end
    repeat (2 * CPB + 2) @(negedge wb_clk);
    wb_rst_n = 1'b0;
    @(negedge wb_clk);
    checks++; if (o_q !== 1'b1)          begin errors++; $display("FAIL midrst_q got %b want 1", o_q); end
    checks++; if (o_frame_cnt !== 16'd0) begin errors++; $display("FAIL midrst_cnt got %0d want 0", o_frame_cnt); end
    checks++; if (o_busy !== 1'b0)       begin errors++; $display("FAIL midrst_busy got %b want 0", o_busy); end
    wb_rst_n = 1'b1;
    repeat (600) @(negedge wb_clk);
    checks++; if (rx_bytes.size() != 1)    begin errors++; $display("FAIL midrst_bytes got %0d want 1", rx_bytes.size()); end
    checks++; if (start_times.size() != 2) begin errors++; $display("FAIL midrst_starts got %0d want 2", start_times.size()); end
    checks++; if (o_frame_cnt !== 16'd0)   begin errors++; $display("FAIL midrst_cnt_after got %0d want 0", o_frame_cnt); end
  endtask

  task automatic test_cksum_pattern();
    do_reset();
    i_decim = 32'd0;
    strobe(16'h1234, 16'h5678);
    build_expected(0);
    wait_idle("pattern", 2000);
    checks++; if (rx_bytes.size() != FB) begin errors++; $display("FAIL pattern_len got %0d want %0d", rx_bytes.size(), FB); end
    for (int i = 0; i < exp_bytes.size() && i < rx_bytes.size(); i++) begin
      checks++; if (rx_bytes[i] !== exp_bytes[i]) begin errors++; $display("FAIL pattern_byte%0d got %h want %h", i, rx_bytes[i], exp_bytes[i]); end
    end
`ifdef SNN_UART_CKSUM_EN
    if (rx_bytes.size() == 6) begin
      checks++; if (rx_bytes[5] !== 8'h08) begin errors++; $display("FAIL pattern_cksum got %h want 08", rx_bytes[5]); end
    end
`endif
  endtask

  task automatic test_random();
    int decim;
    int n;
    int gap;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      decim   = $urandom_range(0, 4);
      n       = $urandom_range(1, 10);
      i_decim = decim;
      for (int i = 0; i < n; i++) begin
        strobe(16'($urandom), 16'($urandom));
        gap = $urandom_range(0, 3);
        repeat (gap) @(negedge wb_clk);
      end
      build_expected(decim);
      wait_idle("random", 8000);
      checks++; if (rx_bytes.size() != exp_bytes.size()) begin errors++; $display("FAIL random%0d_len got %0d want %0d", it, rx_bytes.size(), exp_bytes.size()); end
      for (int i = 0; i < exp_bytes.size() && i < rx_bytes.size(); i++) begin
        checks++; if (rx_bytes[i] !== exp_bytes[i]) begin errors++; $display("FAIL random%0d_byte%0d got %h want %h", it, i, rx_bytes[i], exp_bytes[i]); end
      end
      checks++; if (o_frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL random%0d_cnt got %0d want %0d", it, o_frame_cnt, exp_frames); end
      checks++; if (drop_cnt != exp_drops) begin errors++; $display("FAIL random%0d_drops got %0d want %0d", it, drop_cnt, exp_drops); end
    end
  endtask

  initial begin
    wb_rst_n = 1'b0;
    i_valid  = 1'b0;
    i_p1     = 16'd0;
    i_p2     = 16'd0;
    i_decim  = 32'd1;
    test_reset();
    test_single();
    test_burst("stride", 3, 7);
    test_burst("overflow", 1, 8);
    test_timing();
    test_reset_mid_frame();
    test_cksum_pattern();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
